// File: rtl/mips_cpu_state_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_state_controller
// Purpose  : Multicycle MIPS control unit owning the instruction state
//            register. Sequences FETCH/DECODE/EXEC1/EXEC2, stalls on
//            memory waitrequest, holds MULT/DIV in a bounded MDWAIT state and
//            parks in HALT on a JR to address zero. Per-instruction mux
//            selects stay in the external combinational decoder; this block
//            only produces the timing strobes.
// Ports    : clk, reset_n (async active-low)
//            opcode/fncode/regimm  - instruction fields from the IR
//            waitrequest           - memory not ready this cycle
//            jr_target_zero        - rs == 0, valid in EXEC1
//            state, active         - current state and running flag
//            memread, memwrite, iord, irwrite, pcwrite, pcwritecond,
//            regwrite, muldivwrite - datapath strobes
//            stall                 - state held because of waitrequest
//            illegal               - one-cycle pulse for undecoded encodings
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_state_controller #(
    parameter int MULDIV_CYCLES   = 32,   // legal range 1..64
    parameter int HALT_ON_PC_ZERO = 1,
    parameter int STALL_ON_WAIT   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] fncode,
    input  logic [4:0] regimm,
    input  logic       waitrequest,
    input  logic       jr_target_zero,
    output logic [2:0] state,
    output logic       active,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       regwrite,
    output logic       muldivwrite,
    output logic       stall,
    output logic       illegal
);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_fetch  = 3'd1;
    localparam logic [2:0] c_s_decode = 3'd2;
    localparam logic [2:0] c_s_exec1  = 3'd3;
    localparam logic [2:0] c_s_exec2  = 3'd4;
    localparam logic [2:0] c_s_mdwait = 3'd5;
    localparam logic [2:0] c_s_halt   = 3'd7;

    // Counter counts down to zero, so MDWAIT lasts exactly MULDIV_CYCLES.
    localparam logic [5:0] c_md_load = 6'(MULDIV_CYCLES - 1);

    logic [2:0] r_state;
    logic [5:0] r_md_cnt;
    logic [2:0] w_next_state;
    logic [5:0] w_md_cnt_next;
    logic       w_wait;

    // Instruction class decode
    logic w_alu, w_branch, w_jump, w_jr, w_link, w_load, w_store, w_mt, w_md;

    // Only the link bit of the REGIMM rt field matters to this block.
    logic w_unused_regimm;
    assign w_unused_regimm = &{1'b0, regimm[3:0]};

    assign w_wait = waitrequest & (STALL_ON_WAIT != 0);

    always_comb begin
        w_alu    = 1'b0;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_jr     = 1'b0;
        w_link   = 1'b0;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_mt     = 1'b0;
        w_md     = 1'b0;
        case (opcode)
            6'h00: begin
                case (fncode)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b:                 w_alu = 1'b1;
                    6'h08: begin
                        w_jump = 1'b1;
                        w_jr   = 1'b1;
                    end
                    6'h09: begin
                        w_jump = 1'b1;
                        w_link = 1'b1;
                    end
                    6'h11, 6'h13:                 w_mt  = 1'b1;
                    6'h18, 6'h19, 6'h1a, 6'h1b:   w_md  = 1'b1;
                    default: ;
                endcase
            end
            6'h01: begin
                w_branch = 1'b1;
                w_link   = regimm[4];   // BLTZAL/BGEZAL write $ra
            end
            6'h02: w_jump = 1'b1;
            6'h03: begin
                w_jump = 1'b1;
                w_link = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07:                 w_branch = 1'b1;
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: w_alu = 1'b1;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:          w_load   = 1'b1;
            6'h28, 6'h29, 6'h2b:                        w_store  = 1'b1;
            default: ;
        endcase
    end

    // Strobes and next state; everything is zero unless a state raises it,
    // which keeps IDLE and HALT silent regardless of inputs.
    always_comb begin
        w_next_state  = r_state;
        w_md_cnt_next = r_md_cnt;
        memread       = 1'b0;
        memwrite      = 1'b0;
        iord          = 1'b0;
        irwrite       = 1'b0;
        pcwrite       = 1'b0;
        pcwritecond   = 1'b0;
        regwrite      = 1'b0;
        muldivwrite   = 1'b0;
        stall         = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            c_s_idle: w_next_state = c_s_fetch;
            c_s_fetch: begin
                memread = 1'b1;
                if (w_wait) begin
                    stall = 1'b1;
                end else begin
                    irwrite      = 1'b1;
                    pcwrite      = 1'b1;
                    w_next_state = c_s_decode;
                end
            end
            c_s_decode: w_next_state = c_s_exec1;
            c_s_exec1: begin
                if (w_load) begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    if (w_wait) stall = 1'b1;
                    else        w_next_state = c_s_exec2;
                end else if (w_store) begin
                    // memwrite stays asserted through the stall
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    if (w_wait) stall = 1'b1;
                    else        w_next_state = c_s_fetch;
                end else if (w_alu) begin
                    regwrite     = 1'b1;
                    w_next_state = c_s_fetch;
                end else if (w_branch) begin
                    pcwritecond  = 1'b1;
                    regwrite     = w_link;
                    w_next_state = c_s_fetch;
                end else if (w_jump) begin
                    pcwrite  = 1'b1;
                    regwrite = w_link;
                    if (w_jr && jr_target_zero && (HALT_ON_PC_ZERO != 0))
                        w_next_state = c_s_halt;
                    else
                        w_next_state = c_s_fetch;
                end else if (w_mt) begin
                    muldivwrite  = 1'b1;
                    w_next_state = c_s_fetch;
                end else if (w_md) begin
                    w_md_cnt_next = c_md_load;
                    w_next_state  = c_s_mdwait;
                end else begin
                    illegal      = 1'b1;
                    w_next_state = c_s_fetch;
                end
            end
            c_s_exec2: begin
                regwrite     = 1'b1;
                iord         = 1'b1;
                w_next_state = c_s_fetch;
            end
            c_s_mdwait: begin
                if (r_md_cnt == 6'd0) begin
                    muldivwrite  = 1'b1;
                    w_next_state = c_s_fetch;
                end else begin
                    w_md_cnt_next = r_md_cnt - 6'd1;
                end
            end
            c_s_halt: w_next_state = c_s_halt;
            default:  w_next_state = c_s_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_s_idle;
            r_md_cnt <= 6'd0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    assign state  = r_state;
    assign active = (r_state != c_s_idle) && (r_state != c_s_halt);

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_state_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_state_controller
// Purpose  : Self-checking bench for mips_cpu_state_controller. Instance 0
//            uses MULDIV_CYCLES=32/HALT_ON_PC_ZERO=1, instance 1 uses
//            MULDIV_CYCLES=1/HALT_ON_PC_ZERO=0. A per-instruction model
//            expands each instruction into its expected cycle sequence.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_cpu_state_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rn [2];
    logic [5:0] op [2];
    logic [5:0] fn [2];
    logic [4:0] ri [2];
    logic       wr [2];
    logic       jz [2];
    logic [2:0] st [2];
    logic       act[2], mr[2], mw[2], io[2], irw[2], pcw[2];
    logic       pcc[2], rw[2], mdw[2], stl[2], ill[2];

    mips_cpu_state_controller #(
        .MULDIV_CYCLES(32), .HALT_ON_PC_ZERO(1), .STALL_ON_WAIT(1)
    ) u_dut0 (
        .clk(clk), .reset_n(rn[0]), .opcode(op[0]), .fncode(fn[0]),
        .regimm(ri[0]), .waitrequest(wr[0]), .jr_target_zero(jz[0]),
        .state(st[0]), .active(act[0]), .memread(mr[0]), .memwrite(mw[0]),
        .iord(io[0]), .irwrite(irw[0]), .pcwrite(pcw[0]),
        .pcwritecond(pcc[0]), .regwrite(rw[0]), .muldivwrite(mdw[0]),
        .stall(stl[0]), .illegal(ill[0])
    );

    mips_cpu_state_controller #(
        .MULDIV_CYCLES(1), .HALT_ON_PC_ZERO(0), .STALL_ON_WAIT(1)
    ) u_dut1 (
        .clk(clk), .reset_n(rn[1]), .opcode(op[1]), .fncode(fn[1]),
        .regimm(ri[1]), .waitrequest(wr[1]), .jr_target_zero(jz[1]),
        .state(st[1]), .active(act[1]), .memread(mr[1]), .memwrite(mw[1]),
        .iord(io[1]), .irwrite(irw[1]), .pcwrite(pcw[1]),
        .pcwritecond(pcc[1]), .regwrite(rw[1]), .muldivwrite(mdw[1]),
        .stall(stl[1]), .illegal(ill[1])
    );

    // Strobe masks, in observation-vector order below active
    localparam logic [9:0] c_mr  = 10'h200;
    localparam logic [9:0] c_mw  = 10'h100;
    localparam logic [9:0] c_io  = 10'h080;
    localparam logic [9:0] c_irw = 10'h040;
    localparam logic [9:0] c_pcw = 10'h020;
    localparam logic [9:0] c_pcc = 10'h010;
    localparam logic [9:0] c_rw  = 10'h008;
    localparam logic [9:0] c_mdw = 10'h004;
    localparam logic [9:0] c_stl = 10'h002;
    localparam logic [9:0] c_ill = 10'h001;

    localparam int c_k_alu = 0, c_k_br = 1, c_k_j = 2, c_k_jr = 3, c_k_ld = 4;
    localparam int c_k_st = 5, c_k_mt = 6, c_k_md = 7, c_k_ill = 8;

    typedef struct packed {
        logic        w;
        logic [5:0]  o;
        logic [5:0]  f;
        logic [4:0]  r;
        logic        j;
        logic [13:0] e;
    } entry_t;

    entry_t q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    function automatic int md_cycles(int d);
        return (d == 0) ? 32 : 1;
    endfunction

    function automatic bit halt_en(int d);
        return (d == 0);
    endfunction

    function automatic int classify(logic [5:0] o, logic [5:0] f);
        if (o == 6'd0) begin
            if (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10,
                          6'h12, [6'h20:6'h27], 6'h2a, 6'h2b}) return c_k_alu;
            if (f == 6'h08) return c_k_jr;
            if (f == 6'h09) return c_k_j;
            if (f inside {6'h11, 6'h13}) return c_k_mt;
            if (f inside {[6'h18:6'h1b]}) return c_k_md;
            return c_k_ill;
        end
        if (o inside {[6'h09:6'h0f]}) return c_k_alu;
        if (o inside {6'h01, [6'h04:6'h07]}) return c_k_br;
        if (o inside {6'h02, 6'h03}) return c_k_j;
        if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return c_k_ld;
        if (o inside {6'h28, 6'h29, 6'h2b}) return c_k_st;
        return c_k_ill;
    endfunction

    function automatic bit links(logic [5:0] o, logic [5:0] f, logic [4:0] r);
        return (o == 6'h03) || (o == 6'h00 && f == 6'h09) ||
               (o == 6'h01 && r[4]);
    endfunction

    function automatic logic [13:0] ev(int s, logic [9:0] m);
        return {3'(s), (s >= 1 && s <= 5), m};
    endfunction

    function automatic logic [13:0] obs(int d);
        return {st[d], act[d], mr[d], mw[d], io[d], irw[d], pcw[d], pcc[d],
                rw[d], mdw[d], stl[d], ill[d]};
    endfunction

    task automatic push(logic w, logic [5:0] o, logic [5:0] f, logic [4:0] r,
                        logic j, logic [13:0] e);
        entry_t x;
        x.w = w; x.o = o; x.f = f; x.r = r; x.j = j; x.e = e;
        q.push_back(x);
    endtask

    // Cycle whose decode inputs must not matter: randomise them all
    task automatic push_rand(logic w, logic [13:0] e);
        push(w, 6'($urandom), 6'($urandom), 5'($urandom), 1'($urandom), e);
    endtask

    task automatic check(int d, string tag, logic [13:0] e);
        logic [13:0] o;
        o = obs(d);
        checks++;
        assert (o === e) passes++;
        else begin
            fails++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, d, o, e);
        end
    endtask

    // Expand one instruction into its expected cycles. fs/es are the
    // number of waitrequest cycles in FETCH and in the memory EXEC1 phase.
    task automatic build(int d, logic [5:0] o, logic [5:0] f, logic [4:0] r,
                         logic j, int fs, int es, output bit halted);
        int k;
        logic lk;
        halted = 1'b0;
        k  = classify(o, f);
        lk = links(o, f, r);
        for (int i = 0; i < fs; i++) push_rand(1'b1, ev(1, c_mr | c_stl));
        push_rand(1'b0, ev(1, c_mr | c_irw | c_pcw));
        push(1'($urandom), o, f, r, j, ev(2, 10'h0));
        case (k)
            c_k_alu: push(1'($urandom), o, f, r, j, ev(3, c_rw));
            c_k_br:  push(1'($urandom), o, f, r, j, ev(3, c_pcc | (lk ? c_rw : 10'h0)));
            c_k_j:   push(1'($urandom), o, f, r, j, ev(3, c_pcw | (lk ? c_rw : 10'h0)));
            c_k_jr: begin
                push(1'($urandom), o, f, r, j, ev(3, c_pcw));
                if (j && halt_en(d)) begin
                    halted = 1'b1;
                    for (int i = 0; i < 20; i++) push_rand(1'($urandom), ev(7, 10'h0));
                end
            end
            c_k_ld: begin
                for (int i = 0; i < es; i++) push(1'b1, o, f, r, j, ev(3, c_mr | c_io | c_stl));
                push(1'b0, o, f, r, j, ev(3, c_mr | c_io));
                push(1'($urandom), o, f, r, j, ev(4, c_rw | c_io));
            end
            c_k_st: begin
                for (int i = 0; i < es; i++) push(1'b1, o, f, r, j, ev(3, c_mw | c_io | c_stl));
                push(1'b0, o, f, r, j, ev(3, c_mw | c_io));
            end
            c_k_mt: push(1'($urandom), o, f, r, j, ev(3, c_mdw));
            c_k_md: begin
                push(1'($urandom), o, f, r, j, ev(3, 10'h0));
                for (int i = 0; i < md_cycles(d) - 1; i++)
                    push(1'($urandom), o, f, r, j, ev(5, 10'h0));
                push(1'($urandom), o, f, r, j, ev(5, c_mdw));
            end
            default: push(1'($urandom), o, f, r, j, ev(3, c_ill));
        endcase
    endtask

    task automatic run_q(int d, string tag);
        entry_t x;
        int n = 0;
        while (q.size() > 0) begin
            x = q.pop_front();
            @(posedge clk);
            #1;
            wr[d] = x.w; op[d] = x.o; fn[d] = x.f; ri[d] = x.r; jz[d] = x.j;
            #1;
            check(d, $sformatf("%s_c%0d", tag, n), x.e);
            n++;
        end
    endtask

    task automatic reset_dut(int d);
        @(negedge clk);
        wr[d] = 1'b1;
        rn[d] = 1'b0;
        #1 check(d, "reset", ev(0, 10'h0));
        @(negedge clk);
        rn[d] = 1'b1;
        #1 check(d, "idle", ev(0, 10'h0));
    endtask

    task automatic one(int d, string tag, logic [5:0] o, logic [5:0] f,
                       logic [4:0] r, logic j, int fs, int es);
        bit h;
        build(d, o, f, r, j, fs, es, h);
        run_q(d, tag);
        if (h) reset_dut(d);
    endtask

    task automatic rand_instr(output logic [5:0] o, output logic [5:0] f,
                              output logic [4:0] r);
        logic [5:0] ld_ops [5];
        logic [5:0] st_ops [3];
        ld_ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        st_ops = '{6'h28, 6'h29, 6'h2b};
        o = 6'($urandom); f = 6'($urandom); r = 5'($urandom);
        case ($urandom_range(0, 9))
            0, 1: o = 6'h00;
            2: o = 6'($urandom_range(9, 15));
            3: o = 6'($urandom_range(1, 7));
            4: o = ld_ops[$urandom_range(0, 4)];
            5: o = st_ops[$urandom_range(0, 2)];
            6: begin o = 6'h00; f = 6'($urandom_range(24, 27)); end
            7: begin o = 6'h00; f = 6'($urandom_range(16, 19)); end
            8: ;
            default: begin o = 6'h00; f = 6'($urandom_range(8, 9)); end
        endcase
    endtask

    initial begin
        logic [5:0] o, f;
        logic [4:0] r;
        bit h;
        for (int d = 0; d < 2; d++) begin
            rn[d] = 1'b0; op[d] = 6'h09; fn[d] = 6'h00; ri[d] = 5'h0;
            wr[d] = 1'b0; jz[d] = 1'b0;
        end
        #1;
        check(0, "por", ev(0, 10'h0));
        check(1, "por", ev(0, 10'h0));
        reset_dut(0);

        // Directed sequence on instance 0
        one(0, "addiu", 6'h09, 6'h00, 5'h00, 1'b0, 0, 0);
        one(0, "lw",    6'h23, 6'h00, 5'h00, 1'b0, 2, 3);
        one(0, "sw",    6'h2b, 6'h00, 5'h00, 1'b0, 0, 1);
        one(0, "mult",  6'h00, 6'h18, 5'h00, 1'b0, 0, 0);
        one(0, "bgezal", 6'h01, 6'h00, 5'h11, 1'b0, 1, 0);
        one(0, "bltz",  6'h01, 6'h00, 5'h00, 1'b0, 0, 0);
        one(0, "beq",   6'h04, 6'h00, 5'h00, 1'b0, 0, 0);
        one(0, "jal",   6'h03, 6'h00, 5'h00, 1'b0, 0, 0);
        one(0, "jalr",  6'h00, 6'h09, 5'h00, 1'b1, 0, 0);
        one(0, "jr_nz", 6'h00, 6'h08, 5'h00, 1'b0, 0, 0);
        one(0, "mthi",  6'h00, 6'h11, 5'h00, 1'b0, 0, 0);
        one(0, "ill3f", 6'h3f, 6'h00, 5'h00, 1'b0, 0, 0);
        one(0, "jr_z",  6'h00, 6'h08, 5'h00, 1'b1, 0, 0);

        // Random instruction stream on instance 0
        for (int i = 0; i < 40; i++) begin
            rand_instr(o, f, r);
            one(0, $sformatf("rnd%0d", i), o, f, r, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Store stalled 4 cycles, then reset asserted during the 5th
        build(0, 6'h2b, 6'h00, 5'h00, 1'b0, 0, 4, h);
        void'(q.pop_back());
        run_q(0, "sw_rst");
        @(posedge clk);
        #1 wr[0] = 1'b1;
        #1 rn[0] = 1'b0;
        #1 check(0, "async_rst", ev(0, 10'h0));
        @(negedge clk);
        rn[0] = 1'b1;
        #1 check(0, "rst_idle", ev(0, 10'h0));
        one(0, "post_rst", 6'h0d, 6'h00, 5'h00, 1'b0, 0, 0);

        // Instance 1: one-cycle MDWAIT, JR to zero is an ordinary jump
        reset_dut(1);
        one(1, "mult1", 6'h00, 6'h18, 5'h00, 1'b0, 0, 0);
        one(1, "jr_z_nohalt", 6'h00, 6'h08, 5'h00, 1'b1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            rand_instr(o, f, r);
            one(1, $sformatf("rnd1_%0d", i), o, f, r, 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
